// File: rtl/period_meter_if.sv
// Handshake bundle between period_meter and its consumer.
// PERIOD_METER_HIGH_TIME_EN adds the high_time result field.
interface period_meter_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             ack;
    logic             busy;
    logic             valid;
    logic             overflow;
    logic [CNT_W-1:0] period;
`ifdef PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] high_time;

    modport master (output start, ack, input busy, valid, overflow, period, high_time);
    modport slave  (input start, ack, output busy, valid, overflow, period, high_time);
`else
    modport master (output start, ack, input busy, valid, overflow, period);
    modport slave  (input start, ack, output busy, valid, overflow, period);
`endif
endinterface

// File: rtl/period_meter.sv
// Measures the period of an asynchronous signal in clk cycles, rising edge to rising edge.
// Define PERIOD_METER_HIGH_TIME_EN to also measure the high time within that period.
module period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    period_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == ALL_ONES) ? v : v + ONE;
    endfunction

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   sig_d;
    logic                   sig_s;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       period_r;
    logic                   overflow_r;
    logic                   busy_r;
    logic                   valid_r;
`ifdef PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0]       hcnt;
    logic [CNT_W-1:0]       high_time_r;
`endif

    // Only the last synchronizer stage and its delayed copy feed edge detection.
    assign sig_s = sync_p[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sync_p     <= '0;
            sig_d      <= 1'b0;
            cnt        <= '0;
            period_r   <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
            hcnt        <= '0;
            high_time_r <= '0;
`endif
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sig_s;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ARM;
                        busy_r <= 1'b1;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= '0;
`ifdef PERIOD_METER_HIGH_TIME_EN
                        // The edge cycle itself is high, so it starts the count at 1.
                        hcnt  <= ONE;
`endif
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        state      <= DONE;
                        period_r   <= cnt + ONE;
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b0;
                        valid_r    <= 1'b1;
`ifdef PERIOD_METER_HIGH_TIME_EN
                        high_time_r <= hcnt;
`endif
                    end else if (cnt == ALL_ONES) begin
                        state      <= DONE;
                        period_r   <= ALL_ONES;
                        overflow_r <= 1'b1;
                        busy_r     <= 1'b0;
                        valid_r    <= 1'b1;
`ifdef PERIOD_METER_HIGH_TIME_EN
                        high_time_r <= sig_s ? sat_inc(hcnt) : hcnt;
`endif
                    end else begin
                        cnt <= cnt + ONE;
`ifdef PERIOD_METER_HIGH_TIME_EN
                        if (sig_s) hcnt <= sat_inc(hcnt);
`endif
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.valid    = valid_r;
    assign bus.period   = period_r;
    assign bus.overflow = overflow_r;
`ifdef PERIOD_METER_HIGH_TIME_EN
    assign bus.high_time = high_time_r;
`endif
endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: table vectors, random waveforms vs. a
// waveform-level reference model, and hand-written control corner cases.
module tb_period_meter;
    localparam int CNT_W = 8;

    typedef struct {
        int hi;
        int lo;
        int per;
        int ht;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic sig_in;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   wave [0:511];

    always #5 clk = ~clk;

    period_meter_if #(.CNT_W(CNT_W)) bus ();

    period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .bus    (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Period is the distance between the first two rising edges of the level
    // sequence; high time is the number of high samples between them.
    function automatic void ref_model(input int len, output int per, output int ht);
        int  r1 = -1;
        int  r2 = -1;
        bit  prev = 1'b0;
        per = 0;
        ht  = 0;
        for (int i = 0; i < len; i++) begin
            if (wave[i] && !prev) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            prev = wave[i];
        end
        if (r1 >= 0 && r2 > r1) begin
            per = r2 - r1;
            for (int i = r1; i < r2; i++) ht += int'(wave[i]);
        end
    endfunction

    task automatic check_result(input string tag, input int exp_per, input int exp_ov, input int exp_ht);
        bit ok;
        wait_valid(400, ok);
        check({tag, "_valid"}, longint'(ok), 1);
        check({tag, "_period"}, longint'(bus.period), exp_per);
        check({tag, "_overflow"}, longint'(bus.overflow), exp_ov);
        check({tag, "_busy_done"}, longint'(bus.busy), 0);
`ifdef PERIOD_METER_HIGH_TIME_EN
        check({tag, "_high_time"}, longint'(bus.high_time), exp_ht);
`else
        if (exp_ht < 0) $display("unused high time %0d", exp_ht);
`endif
    endtask

    task automatic run_meas(input string tag, input int h, input int l, input bit use_model,
                            input int tbl_per, input int tbl_ht);
        int len = h + l + 4;
        int exp_per = tbl_per;
        int exp_ht  = tbl_ht;
        for (int i = 0; i < len; i++) wave[i] = (i < h) || (i >= h + l);
        if (use_model) ref_model(len, exp_per, exp_ht);
        sig_in   = 1'b0;
        bus.ack  = 1'b0;
        repeat (6) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({tag, "_busy_arm"}, longint'(bus.busy), 1);
        for (int i = 0; i < len; i++) begin
            sig_in = wave[i];
            step();
        end
        check_result(tag, exp_per, 0, exp_ht);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        sig_in  = 1'b0;
        check({tag, "_valid_after_ack"}, longint'(bus.valid), 0);
        check({tag, "_period_retained"}, longint'(bus.period), exp_per);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        bit   ok;
        int   h;
        int   l;
        tbl[0] = '{hi: 10, lo: 10, per: 20, ht: 10};
        tbl[1] = '{hi: 6,  lo: 14, per: 20, ht: 6};
        tbl[2] = '{hi: 1,  lo: 4,  per: 5,  ht: 1};
        tbl[3] = '{hi: 3,  lo: 3,  per: 6,  ht: 3};
        tbl[4] = '{hi: 50, lo: 77, per: 127, ht: 50};
        tbl[5] = '{hi: 100, lo: 154, per: 254, ht: 100};

        reset     = 1'b1;
        sig_in    = 1'b0;
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_valid", longint'(bus.valid), 0);
        check("reset_period", longint'(bus.period), 0);
        check("reset_overflow", longint'(bus.overflow), 0);

        for (int i = 0; i < 6; i++)
            run_meas($sformatf("tbl%0d", i), tbl[i].hi, tbl[i].lo, 1'b0, tbl[i].per, tbl[i].ht);

        for (int i = 0; i < 8; i++) begin
            h = int'($urandom_range(1, 100));
            l = int'($urandom_range(1, 100));
            run_meas($sformatf("rnd%0d", i), h, l, 1'b1, 0, 0);
        end

        // ack outside DONE is ignored; start while busy does not restart.
        repeat (6) step();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("ack_idle_busy", longint'(bus.busy), 0);
        check("ack_idle_valid", longint'(bus.valid), 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.ack   = 1'b1;
        step();
        bus.ack   = 1'b0;
        check("ack_arm_busy", longint'(bus.busy), 1);
        for (int i = 0; i < 16; i++) begin
            sig_in    = (i < 5) || (i >= 12);
            bus.start = (i == 2) || (i == 8);
            step();
        end
        bus.start = 1'b0;
        check_result("restart", 12, 0, 5);
        bus.start = 1'b1;
        bus.ack   = 1'b1;
        step();
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        check("startack_valid", longint'(bus.valid), 0);
        check("startack_busy", longint'(bus.busy), 0);
        step();
        check("startack_busy2", longint'(bus.busy), 0);
        sig_in = 1'b0;

        // Counter saturation: one edge, then no further edge.
        repeat (6) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        sig_in = 1'b1;
        repeat (3) step();
        sig_in = 1'b0;
        check_result("ovf", 255, 1, 3);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("ovf_valid_after_ack", longint'(bus.valid), 0);
        check("ovf_overflow_retained", longint'(bus.overflow), 1);

        // Reset in the middle of a measurement.
        repeat (6) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        sig_in = 1'b1;
        repeat (6) step();
        reset = 1'b1;
        bus.start = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        sig_in = 1'b0;
        check("rst_meas_busy", longint'(bus.busy), 0);
        check("rst_meas_valid", longint'(bus.valid), 0);
        check("rst_meas_period", longint'(bus.period), 0);
        check("rst_meas_overflow", longint'(bus.overflow), 0);
        repeat (20) step();
        check("rst_no_result", longint'(bus.valid), 0);
        run_meas("after_rst", 6, 14, 1'b0, 20, 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of period/high-time counters and results.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_in (legal 2..4).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sig_in  input  1  asynchronous signal to be measured, e.g. a divided clock.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 ack  input  1  consumer acknowledge of a held result.
REQ-008 busy  output  1  high while armed or measuring.
REQ-009 valid  output  1  high while a result is held.
REQ-010 period  output  CNT_W  measured period in clk cycles.
REQ-011 overflow  output  1  high with valid when the counter saturated.
REQ-012 high_time  output  CNT_W  clk cycles sig_in was high in the measured period (present only under PERIOD_METER_HIGH_TIME_EN).

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops; edge detection SHALL use only the last synchronized stage and its one-cycle-delayed copy.
REQ-014 A rising edge SHALL be detected in the cycle where synchronized value is 1 and delayed copy is 0.
REQ-015 FSM states SHALL be IDLE, ARM, MEASURE, DONE.
REQ-016 IDLE: start=1 -> ARM; otherwise stay.
REQ-017 ARM: rising edge -> MEASURE with counter cleared to 0; otherwise stay.
REQ-018 MEASURE: counter SHALL increment by 1 each cycle; on a rising edge SHALL load period with counter+1, overflow with 0, and go to DONE.
REQ-019 Edges detected at cycles t and t+N SHALL yield period = N.
REQ-020 MEASURE: if counter equals all-ones and no edge is detected, SHALL load period with all-ones, overflow with 1, and go to DONE.
REQ-021 DONE: valid=1, period/overflow held stable; ack=1 -> IDLE, valid low the next cycle.
REQ-022 start SHALL be ignored in ARM, MEASURE and DONE; start and ack together in DONE SHALL act as ack only.
REQ-023 ack outside DONE SHALL be ignored.
REQ-024 busy SHALL be 1 exactly in ARM and MEASURE; valid SHALL be 1 exactly in DONE.
REQ-025 period and overflow SHALL retain their last value after leaving DONE until the next load.

Reset
REQ-026 reset SHALL force IDLE, clear synchronizer and delay flops, counter, period, high_time to 0, busy/valid/overflow to 0.
REQ-027 reset asserted in any state SHALL abort the measurement with no result produced; reset takes priority over start and ack.

Configuration
REQ-028 With PERIOD_METER_HIGH_TIME_EN defined, a second counter SHALL clear on entering MEASURE, increment in each MEASURE cycle where the synchronized signal is 1 (including the first-edge cycle via an initial value of 1), saturate at all-ones, and load high_time alongside period.
REQ-029 Without PERIOD_METER_HIGH_TIME_EN, the high_time port and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 reset, start, sig_in square wave of period 20 clk -> valid after second detected edge, period=20, overflow=0.
REQ-031 CNT_W=8, start, sig_in held low after one rising edge -> valid with period=255, overflow=1.
REQ-032 start while busy, and start+ack together in DONE -> no restart; state returns to IDLE, valid drops the next cycle.
REQ-033 reset asserted in MEASURE -> next cycle busy=0, valid=0, period=0; following start measures correctly.
REQ-034 Macro defined, sig_in high 6 / low 14 clk -> period=20, high_time=6.
REQ-035 sig_in glitch-free edge arriving 1 cycle after start -> edge detection delayed by SYNC_STAGES+1 cycles relative to sig_in; period unaffected.
